// File: rtl/voice_allocator.sv
`default_nettype none
// voice_allocator: assigns decoded MIDI note events to N_VOICES voices in LRU order.
// Optional build macro VOICE_STEAL_EN: steal the least recently allocated busy voice when none is free.
module voice_allocator #(
  parameter int N_VOICES     = 4,
  parameter int MIDI_CHANNEL = 16
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            midi_valid_in,
  input  logic [23:0]                     midi_event_in,
  output logic                            ready_out,
  output logic                            dropped_out,
  output logic [N_VOICES-1:0]             gate_out,
  output logic [N_VOICES-1:0]             trigger_out,
  output logic [7*N_VOICES-1:0]           note_out,
  output logic [7*N_VOICES-1:0]           velocity_out,
  output logic [$clog2(N_VOICES+1)-1:0]   active_count_out
);
  localparam int         RW   = $clog2(N_VOICES);
  localparam int         CW   = $clog2(N_VOICES+1);
  localparam logic [4:0] C_CH = 5'(MIDI_CHANNEL);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;
  typedef enum logic [1:0] {K_NONE, K_ON, K_OFF, K_ALL} kind_t;

  state_t              r_state, w_state_nxt;
  kind_t               r_kind, w_kind;
  logic [7:0]          r_d1;
  logic [6:0]          r_d2;
  logic [RW-1:0]       r_idx;
  logic [RW-1:0]       r_rank [N_VOICES];
  logic [6:0]          r_note [N_VOICES];
  logic [6:0]          r_vel  [N_VOICES];
  logic [N_VOICES-1:0] r_gate, r_trig;
  logic [CW-1:0]       r_count;
  logic                r_drop;
  logic                r_m_ok, r_f_ok, r_b_ok;
  logic [RW-1:0]       r_m_idx, r_f_idx, r_b_idx, r_f_rank, r_b_rank;

  logic                w_ch_ok, w_accept, w_tgt_ok, w_steal_drop;
  logic [RW-1:0]       w_tgt;
  logic [N_VOICES-1:0] w_gate_nxt;
  logic [CW-1:0]       w_count_nxt;

  assign w_ch_ok  = (MIDI_CHANNEL == 16) || ({1'b0, midi_event_in[19:16]} == C_CH);
  assign w_accept = midi_valid_in & ready_out;

  always_comb begin
    w_kind = K_NONE;
    if (w_ch_ok) begin
      if (midi_event_in[23:20] == 4'h9 && midi_event_in[7:0] != 8'h00)
        w_kind = K_ON;
      else if (midi_event_in[23:20] == 4'h8 || midi_event_in[23:20] == 4'h9)
        w_kind = K_OFF;
      else if (midi_event_in[23:20] == 4'hB && midi_event_in[15:8] == 8'h7B)
        w_kind = K_ALL;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready_out   = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_out = 1'b1;
        if (midi_valid_in) begin
          if (w_kind == K_ON || w_kind == K_OFF) w_state_nxt = S_SCAN;
          else if (w_kind == K_ALL)              w_state_nxt = S_COMMIT;
        end
      end
      S_SCAN:   if (r_idx == RW'(N_VOICES-1)) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Target selection priority: matching held note, then LRU free voice, then LRU busy voice.
  always_comb begin
    w_tgt_ok     = 1'b0;
    w_tgt        = r_m_idx;
    w_steal_drop = 1'b0;
    w_gate_nxt   = r_gate;
    if (r_state == S_COMMIT) begin
      case (r_kind)
        K_ON: begin
          if (r_m_ok) begin
            w_tgt_ok = 1'b1;
          end else if (r_f_ok) begin
            w_tgt_ok = 1'b1;
            w_tgt    = r_f_idx;
          end else begin
`ifdef VOICE_STEAL_EN
            w_tgt_ok = r_b_ok;
            w_tgt    = r_b_idx;
`else
            w_steal_drop = 1'b1;
`endif
          end
          if (w_tgt_ok) w_gate_nxt[w_tgt] = 1'b1;
        end
        K_OFF:   if (r_m_ok) w_gate_nxt[r_m_idx] = 1'b0;
        K_ALL:   w_gate_nxt = '0;
        default: w_gate_nxt = r_gate;
      endcase
    end
  end

  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < N_VOICES; i++) w_count_nxt = w_count_nxt + CW'(w_gate_nxt[i]);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_kind   <= K_NONE;
      r_d1     <= '0;
      r_d2     <= '0;
      r_idx    <= '0;
      r_gate   <= '0;
      r_trig   <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
      r_m_ok   <= 1'b0;
      r_f_ok   <= 1'b0;
      r_b_ok   <= 1'b0;
      r_m_idx  <= '0;
      r_f_idx  <= '0;
      r_b_idx  <= '0;
      r_f_rank <= '0;
      r_b_rank <= '0;
      for (int i = 0; i < N_VOICES; i++) begin
        r_rank[i] <= RW'(N_VOICES-1-i);
        r_note[i] <= '0;
        r_vel[i]  <= '0;
      end
    end else begin
      r_trig <= '0;
      r_drop <= (midi_valid_in & ~ready_out) | w_steal_drop;
      if (w_accept && w_kind != K_NONE) begin
        r_kind <= w_kind;
        r_d1   <= midi_event_in[15:8];
        r_d2   <= midi_event_in[6:0];
        r_idx  <= '0;
        r_m_ok <= 1'b0;
        r_f_ok <= 1'b0;
        r_b_ok <= 1'b0;
      end
      if (r_state == S_SCAN) begin
        if (r_gate[r_idx]) begin
          if (!r_m_ok && {1'b0, r_note[r_idx]} == r_d1) begin
            r_m_ok  <= 1'b1;
            r_m_idx <= r_idx;
          end
          if (!r_b_ok || r_rank[r_idx] > r_b_rank) begin
            r_b_ok   <= 1'b1;
            r_b_idx  <= r_idx;
            r_b_rank <= r_rank[r_idx];
          end
        end else if (!r_f_ok || r_rank[r_idx] > r_f_rank) begin
          r_f_ok   <= 1'b1;
          r_f_idx  <= r_idx;
          r_f_rank <= r_rank[r_idx];
        end
        r_idx <= r_idx + 1'b1;
      end
      if (r_state == S_COMMIT) begin
        r_gate  <= w_gate_nxt;
        r_count <= w_count_nxt;
        if (w_tgt_ok) begin
          r_note[w_tgt] <= r_d1[6:0];
          r_vel[w_tgt]  <= r_d2;
          r_trig[w_tgt] <= 1'b1;
          for (int i = 0; i < N_VOICES; i++) begin
            if (i == int'(w_tgt))              r_rank[i] <= '0;
            else if (r_rank[i] < r_rank[w_tgt]) r_rank[i] <= r_rank[i] + 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < N_VOICES; g++) begin : g_pack
    assign note_out[7*g +: 7]     = r_note[g];
    assign velocity_out[7*g +: 7] = r_vel[g];
  end

  assign gate_out         = r_gate;
  assign trigger_out      = r_trig;
  assign dropped_out      = r_drop;
  assign active_count_out = r_count;
endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// tb_voice_allocator: directed MIDI events checked each cycle against an LRU-queue voice model.
module tb_voice_allocator;
  localparam int N = 4;

  logic clk = 1'b0, rst = 1'b1, vin = 1'b0;
  logic [23:0] ev = '0;
  logic ready, dropped;
  logic [N-1:0] gate, trig;
  logic [7*N-1:0] note, vel;
  logic [2:0] count;

  logic v2 = 1'b0;
  logic [23:0] e2 = '0;
  logic r2, d2;
  logic [N-1:0] g2, t2;
  logic [7*N-1:0] n2, vl2;
  logic [2:0] c2;

  always #5 clk = ~clk;

  voice_allocator #(.N_VOICES(N), .MIDI_CHANNEL(16)) u_dut (
    .clk_in(clk), .rst_in(rst), .midi_valid_in(vin), .midi_event_in(ev),
    .ready_out(ready), .dropped_out(dropped), .gate_out(gate), .trigger_out(trig),
    .note_out(note), .velocity_out(vel), .active_count_out(count));

  voice_allocator #(.N_VOICES(N), .MIDI_CHANNEL(2)) u_ch2 (
    .clk_in(clk), .rst_in(rst), .midi_valid_in(v2), .midi_event_in(e2),
    .ready_out(r2), .dropped_out(d2), .gate_out(g2), .trigger_out(t2),
    .note_out(n2), .velocity_out(vl2), .active_count_out(c2));

  int n_vec = 0, n_bad = 0;

  // Model: per-voice gate/note/velocity plus an allocation queue, front = least recently allocated.
  bit [N-1:0] m_gate;
  int m_note[N], m_vel[N];
  int q[$];
  bit exp_ready, exp_drop, chk_on = 1'b0;
  bit [N-1:0] exp_trig;
  logic [N-1:0] snap_gate, snap_trig;
  logic snap_drop, snap_poke;

  task automatic model_reset();
    m_gate = '0;
    q = {};
    for (int i = 0; i < N; i++) begin
      m_note[i] = 0;
      m_vel[i] = 0;
      q.push_back(i);
    end
    exp_ready = 1'b1;
    exp_drop = 1'b0;
    exp_trig = '0;
  endtask

  function automatic int kind_of(input logic [23:0] e);
    case (e[23:20])
      4'h9:    return (e[7:0] != 8'h00) ? 1 : 2;
      4'h8:    return 2;
      4'hB:    return (e[15:8] == 8'h7B) ? 3 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_commit(input int k, input logic [23:0] e);
    int m, t;
    m = -1;
    t = -1;
    if (k == 3) begin
      m_gate = '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (m < 0 && m_gate[i] && m_note[i] == int'(e[15:8])) m = i;
      if (k == 2) begin
        if (m >= 0) m_gate[m] = 1'b0;
      end else begin
        if (m >= 0) t = m;
        else foreach (q[j]) if (t < 0 && !m_gate[q[j]]) t = q[j];
`ifdef VOICE_STEAL_EN
        if (t < 0) t = q[0];
`endif
        if (t < 0) begin
          exp_drop = 1'b1;
        end else begin
          m_gate[t] = 1'b1;
          m_note[t] = int'(e[14:8]);
          m_vel[t] = int'(e[6:0]);
          exp_trig[t] = 1'b1;
          foreach (q[j]) if (q[j] == t) begin q.delete(j); break; end
          q.push_back(t);
        end
      end
    end
  endtask

  always @(negedge clk) begin : p_cmp
    logic [7*N-1:0] en, evl;
    if (chk_on) begin
      for (int i = 0; i < N; i++) begin
        en[7*i +: 7] = 7'(m_note[i]);
        evl[7*i +: 7] = 7'(m_vel[i]);
      end
      n_vec++;
      if (ready !== exp_ready || dropped !== exp_drop || gate !== m_gate || trig !== exp_trig ||
          count !== 3'($countones(m_gate)) || note !== en || vel !== evl) begin
        n_bad++;
        $display("FAIL cycle@%0t: got rdy=%b drp=%b gate=%b trig=%b cnt=%0d note=%h vel=%h, want rdy=%b drp=%b gate=%b trig=%b cnt=%0d note=%h vel=%h",
                 $time, ready, dropped, gate, trig, count, note, vel,
                 exp_ready, exp_drop, m_gate, exp_trig, $countones(m_gate), en, evl);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] e, input int poke = 0);
    int k, lat;
    k = kind_of(e);
    vin = 1'b1;
    ev = e;
    tick();
    vin = 1'b0;
    if (k == 0) return;
    exp_ready = 1'b0;
    lat = (k == 3) ? 1 : N + 1;
    for (int c = 1; c <= lat; c++) begin
      if (c == poke) begin
        vin = 1'b1;
        ev = 24'h90_48_40;
      end
      tick();
      vin = 1'b0;
      exp_drop = (c == poke);
      if (c == poke) snap_poke = dropped;
      if (c == lat) begin
        model_commit(k, e);
        exp_ready = 1'b1;
        snap_gate = gate;
        snap_trig = trig;
        snap_drop = dropped;
      end
    end
    tick();
    exp_trig = '0;
    exp_drop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    chk_on = 1'b1;
    lit("reset_ready", ready, 1);
    lit("reset_gate", gate, 0);

    v2 = 1'b1; e2 = 24'h91_3C_64; tick(); v2 = 1'b0;
    lit("ch2_ignore_ready", r2, 1);
    repeat (N + 2) tick();
    lit("ch2_ignore_gate", g2, 0);
    v2 = 1'b1; e2 = 24'h92_3C_64; tick(); v2 = 1'b0;
    lit("ch2_accept_ready", r2, 0);
    repeat (N + 1) tick();
    lit("ch2_gate", g2, 1);
    lit("ch2_note0", n2[6:0], 60);

    send(24'h90_3C_64);
    lit("first_gate", snap_gate, 4'b0001);
    lit("first_note0", note[6:0], 60);
    lit("first_vel0", vel[6:0], 100);
    lit("first_trig", snap_trig, 4'b0001);
    lit("first_count", count, 1);
    send(24'h90_3E_50);
    send(24'h90_40_50);
    send(24'h90_41_50);
    lit("fill_gate", gate, 4'b1111);
    send(24'h90_43_50);
`ifdef VOICE_STEAL_EN
    lit("steal_note0", note[6:0], 67);
    lit("steal_trig", snap_trig, 4'b0001);
`else
    lit("nosteal_note0", note[6:0], 60);
    lit("nosteal_drop", snap_drop, 1);
`endif

    do_reset();
    send(24'h90_3C_64);
    send(24'h90_3E_64);
    send(24'h80_3C_00);
    lit("off_gate", gate, 4'b0010);
    lit("off_note0_held", note[6:0], 60);
    send(24'h90_46_64);
    lit("reuse_note2", note[20:14], 70);
    lit("reuse_gate", gate, 4'b0110);

    send(24'h90_3C_64);
    lit("held_trig", snap_trig, 4'b1000);
    send(24'h90_3C_20);
    lit("retrig_trig", snap_trig, 4'b1000);
    lit("retrig_vel3", vel[27:21], 32);
    lit("retrig_count", count, 3);
    send(24'h90_3C_00);
    lit("vel0_off_gate", gate, 4'b0110);

    send(24'h90_30_40, 2);
    lit("busy_drop", snap_poke, 1);
    send(24'hB0_7B_00);
    lit("alloff_gate", snap_gate, 4'b0000);

    send(24'hE0_00_40);
    lit("bend_ready", ready, 1);
    send(24'hC0_05_00);
    lit("pgm_ready", ready, 1);

    send(24'h90_30_50);
    vin = 1'b1; ev = 24'h90_3C_64; tick(); vin = 1'b0;
    exp_ready = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    lit("midrst_ready", ready, 1);
    lit("midrst_gate", gate, 0);
    lit("midrst_note", note, 0);
    send(24'h90_3E_64);
    lit("post_rst_gate", gate, 4'b0001);
    lit("post_rst_note0", note[6:0], 62);

    tick();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
